// File: rtl/seq_compare_n.sv
// Multi-cycle magnitude comparator: scans 4-bit slices MSB-first and reports
// A>B / A<B / A==B with a valid/ready handshake on both sides.
module seq_compare_n #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             QAGB,
    output logic             QASB,
    output logic             QAEB,
    output logic [6:0]       slices_used
);

    localparam int NS = WIDTH / 4;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [NS-1:0][3:0]  a_q, b_q;
    logic                sgn_q;
    logic [IW-1:0]       idx_q;
    logic                found_q;
    logic [3:0]          sa, sb;
    logic                last, diff;

    // Flipping the sign bit of the top slice turns a two's-complement order
    // into an unsigned one, so the rest of the scan stays unsigned.
    always_comb begin
        sa = a_q[idx_q];
        sb = b_q[idx_q];
        if (sgn_q && (idx_q == IW'(NS - 1))) begin
            sa[3] = ~sa[3];
            sb[3] = ~sb[3];
        end
        last = (idx_q == '0);
        diff = !found_q && (sa != sb);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if ((diff && EARLY_EXIT != 0) || last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            QAGB        <= 1'b0;
            QASB        <= 1'b0;
            QAEB        <= 1'b0;
            slices_used <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= DataA;
                        b_q         <= DataB;
                        sgn_q       <= signed_mode;
                        idx_q       <= IW'(NS - 1);
                        found_q     <= 1'b0;
                        slices_used <= '0;
                    end
                end
                RUN: begin
                    slices_used <= slices_used + 7'd1;
                    // Results are only rewritten at the decision point so they
                    // keep the previous answer until a new one exists.
                    if (diff) begin
                        QAGB    <= (sa > sb);
                        QASB    <= (sa < sb);
                        QAEB    <= 1'b0;
                        found_q <= 1'b1;
                    end else if (last && !found_q) begin
                        QAGB <= 1'b0;
                        QASB <= 1'b0;
                        QAEB <= 1'b1;
                    end
                    if (!last) idx_q <= idx_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
